// File: rtl/gpmc_initiator.sv
// Address/data-multiplexed GPMC bus initiator: converts single-word valid/ready
// commands into GPMC bus cycles, with every bus transition aligned to gpmc_clk rising.
module gpmc_initiator #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  gpmc_clk,
  output logic                  gpmc_csn,
  output logic                  gpmc_advn,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_ADDR,
    S_WDATA,
    S_RWAIT,
    S_END
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  state_t                  state_q;
  logic                    gclk_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              cnt_q;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    csn_q;
  logic                    advn_q;
  logic                    wein_q;
  logic                    oen_q;
  logic [DATA_WIDTH-1:0]   ad_out_q;
  logic                    ad_oe_q;

  logic                    bus_edge;
  logic [DATA_WIDTH-1:0]   addr_ext_d;

  // This clk edge drives gpmc_clk 0->1; the responder samples mid-tick on the fall.
  assign bus_edge = ~gclk_q;

  always_comb begin
    addr_ext_d = '0;
    addr_ext_d[ADDR_WIDTH-1:0] = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gclk_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      csn_q       <= 1'b1;
      advn_q      <= 1'b1;
      wein_q      <= 1'b1;
      oen_q       <= 1'b1;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
    end else begin
      gclk_q      <= ~gclk_q;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            we_q        <= cmd_we;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            state_q     <= S_PEND;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_PEND: begin
          if (bus_edge) begin
            csn_q    <= 1'b0;
            advn_q   <= 1'b0;
            wein_q   <= 1'b1;
            oen_q    <= 1'b1;
            ad_oe_q  <= 1'b1;
            ad_out_q <= addr_ext_d;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_edge) begin
            advn_q <= 1'b1;
            if (we_q) begin
              wein_q   <= 1'b0;
              ad_out_q <= wdata_q;
              ad_oe_q  <= 1'b1;
              state_q  <= S_WDATA;
            end else begin
              // Release AD on the same edge OEn falls so the two drivers never overlap.
              oen_q    <= 1'b0;
              ad_oe_q  <= 1'b0;
              ad_out_q <= '0;
              cnt_q    <= LAT_INIT;
              state_q  <= S_RWAIT;
            end
          end
        end
        S_WDATA: begin
          if (bus_edge) begin
            csn_q       <= 1'b1;
            wein_q      <= 1'b1;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= S_END;
          end
        end
        S_RWAIT: begin
          if (bus_edge) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              rsp_rdata_q <= gpmc_ad_in;
              rsp_valid_q <= 1'b1;
              csn_q       <= 1'b1;
              oen_q       <= 1'b1;
              state_q     <= S_END;
            end
          end
        end
        S_END: begin
          if (bus_edge) begin
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign gpmc_clk    = gclk_q;
  assign gpmc_csn    = csn_q;
  assign gpmc_advn   = advn_q;
  assign gpmc_wein   = wein_q;
  assign gpmc_oen    = oen_q;
  assign gpmc_ad_out = ad_out_q;
  assign gpmc_ad_oe  = ad_oe_q;

endmodule
